// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - scan codes, joystick/ctrl bit indices, coin FSM states
package arcade_input_pkg;

  // PS/2 set-2 scan codes
  localparam logic [7:0] KEY_UP          = 8'h75;
  localparam logic [7:0] KEY_DOWN        = 8'h72;
  localparam logic [7:0] KEY_LEFT        = 8'h6B;
  localparam logic [7:0] KEY_RIGHT       = 8'h74;
  localparam logic [7:0] KEY_FIRE_SPACE  = 8'h29;
  localparam logic [7:0] KEY_FIRE_CTRL   = 8'h14;
  localparam logic [7:0] KEY_START1      = 8'h05;
  localparam logic [7:0] KEY_START1_ALT  = 8'h16;
  localparam logic [7:0] KEY_START2      = 8'h06;
  localparam logic [7:0] KEY_START2_ALT  = 8'h1E;
  localparam logic [7:0] KEY_COIN_A      = 8'h2E;
  localparam logic [7:0] KEY_COIN_B      = 8'h36;
  localparam logic [7:0] KEY_P2_UP       = 8'h2D;
  localparam logic [7:0] KEY_P2_DOWN     = 8'h2B;
  localparam logic [7:0] KEY_P2_LEFT     = 8'h23;
  localparam logic [7:0] KEY_P2_RIGHT    = 8'h34;
  localparam logic [7:0] KEY_P2_FIRE     = 8'h1C;

  // HPS joystick word bit positions
  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  // Output control vector {fire,right,left,down,up}
  localparam int CTRL_UP    = 0;
  localparam int CTRL_DOWN  = 1;
  localparam int CTRL_LEFT  = 2;
  localparam int CTRL_RIGHT = 3;
  localparam int CTRL_FIRE  = 4;

  typedef enum logic [1:0] {IDLE, ON, OFF} coin_state_t;

  typedef struct packed {
    logic p1_up;
    logic p1_down;
    logic p1_left;
    logic p1_right;
    logic p1_fire;
    logic start1;
    logic start2;
    logic coin_a;
    logic coin_b;
    logic p2_up;
    logic p2_down;
    logic p2_left;
    logic p2_right;
    logic p2_fire;
  } key_state_t;

  // Horizontal cabinet: the stick is turned a quarter, fire stays put
  function automatic logic [4:0] rotate_ctrl(input logic [4:0] raw, input logic rot);
    logic [4:0] r;
    r = raw;
    if (rot) begin
      r[CTRL_UP]    = raw[CTRL_LEFT];
      r[CTRL_DOWN]  = raw[CTRL_RIGHT];
      r[CTRL_LEFT]  = raw[CTRL_DOWN];
      r[CTRL_RIGHT] = raw[CTRL_UP];
    end
    return r;
  endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// rtl/coin_pulse_gen.sv - saturating coin request queue and timed coin pulse FSM
module coin_pulse_gen
  import arcade_input_pkg::*;
#(
  parameter int COIN_ON_CYCLES  = 1200000,
  parameter int COIN_OFF_CYCLES = 1200000,
  parameter int QUEUE_MAX       = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [2:0] req_count,
  output logic       coin,
  output logic [1:0] pending
);

  localparam int CNT_MAX = (COIN_ON_CYCLES > COIN_OFF_CYCLES) ? COIN_ON_CYCLES : COIN_OFF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(COIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(COIN_OFF_CYCLES - 1);
  localparam logic [3:0] QMAX = 4'(QUEUE_MAX);

  coin_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             pop;
  logic [3:0]       sum;
  logic [1:0]       pending_d;

  // A pending credit is taken when idle, or straight out of the gap so pulses run back to back
  assign pop = (pending != 2'd0) && ((state == IDLE) || ((state == OFF) && (cnt == '0)));

  // Queue depth update: pushes and pop net out, result clamps at QUEUE_MAX
  always_comb begin
    sum       = {2'b00, pending} + {1'b0, req_count} - {3'b000, pop};
    pending_d = (sum > QMAX) ? QMAX[1:0] : sum[1:0];
  end

  // Queue register and pulse FSM with registered coin output
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      coin    <= 1'b0;
      pending <= 2'd0;
    end else begin
      pending <= pending_d;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= ON;
            cnt   <= ON_LOAD;
            coin  <= 1'b1;
          end
        end
        ON: begin
          if (cnt == '0) begin
            state <= OFF;
            cnt   <= OFF_LOAD;
            coin  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OFF: begin
          if (cnt == '0) begin
            if (pop) begin
              state <= ON;
              cnt   <= ON_LOAD;
              coin  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// rtl/arcade_input_ctrl.sv - PS/2 + joystick merge, control rotation, coin request generation
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_ON_CYCLES  = 1200000,
  parameter int COIN_OFF_CYCLES = 1200000,
  parameter int QUEUE_MAX       = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [4:0]  p1_ctrl,
  output logic [4:0]  p2_ctrl,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic [1:0]  coin_pending
);

  key_state_t key_q, key_d;
  logic       toggle_q, primed_q, key_event, pressed, ext;
  logic [7:0] scan;
  logic [6:0] joy_any;
  logic [4:0] p1_raw, p2_raw;
  logic       start1_d, start2_d;
  logic       start1_hist, start2_hist, coin_a_hist, coin_b_hist;
  logic [2:0] req_count;
  logic       unused_joy_hi;

  assign unused_joy_hi = ^{joystick_0[15:7], joystick_1[15:7]};

  assign pressed   = ps2_key[9];
  assign ext       = ps2_key[8];
  assign scan      = ps2_key[7:0];
  assign key_event = primed_q && (ps2_key[10] != toggle_q);
  assign joy_any   = joystick_0[6:0] | joystick_1[6:0];

  // Next key state: arrows accept either prefix, everything else only unprefixed codes
  always_comb begin
    key_d = key_q;
    if (key_event) begin
      case (scan)
        KEY_UP:    key_d.p1_up    = pressed;
        KEY_DOWN:  key_d.p1_down  = pressed;
        KEY_LEFT:  key_d.p1_left  = pressed;
        KEY_RIGHT: key_d.p1_right = pressed;
        default: begin
          if (!ext) begin
            case (scan)
              KEY_FIRE_SPACE, KEY_FIRE_CTRL: key_d.p1_fire  = pressed;
              KEY_START1, KEY_START1_ALT:    key_d.start1   = pressed;
              KEY_START2, KEY_START2_ALT:    key_d.start2   = pressed;
              KEY_COIN_A:                    key_d.coin_a   = pressed;
              KEY_COIN_B:                    key_d.coin_b   = pressed;
              KEY_P2_UP:                     key_d.p2_up    = pressed;
              KEY_P2_DOWN:                   key_d.p2_down  = pressed;
              KEY_P2_LEFT:                   key_d.p2_left  = pressed;
              KEY_P2_RIGHT:                  key_d.p2_right = pressed;
              KEY_P2_FIRE:                   key_d.p2_fire  = pressed;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Keyboard and joystick merge ahead of the output registers
  always_comb begin
    p1_raw             = '0;
    p1_raw[CTRL_UP]    = key_d.p1_up    | joy_any[JOY_U];
    p1_raw[CTRL_DOWN]  = key_d.p1_down  | joy_any[JOY_D];
    p1_raw[CTRL_LEFT]  = key_d.p1_left  | joy_any[JOY_L];
    p1_raw[CTRL_RIGHT] = key_d.p1_right | joy_any[JOY_R];
    p1_raw[CTRL_FIRE]  = key_d.p1_fire  | joy_any[JOY_FIRE];
    p2_raw             = '0;
    p2_raw[CTRL_UP]    = key_d.p2_up    | joystick_1[JOY_U];
    p2_raw[CTRL_DOWN]  = key_d.p2_down  | joystick_1[JOY_D];
    p2_raw[CTRL_LEFT]  = key_d.p2_left  | joystick_1[JOY_L];
    p2_raw[CTRL_RIGHT] = key_d.p2_right | joystick_1[JOY_R];
    p2_raw[CTRL_FIRE]  = key_d.p2_fire  | joystick_1[JOY_FIRE];
    start1_d           = key_d.start1   | joy_any[JOY_START1];
    start2_d           = key_d.start2   | joy_any[JOY_START2];
  end

  // The first cycle out of reset only learns the toggle so a stale event is not replayed
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      primed_q <= 1'b0;
      key_q    <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      primed_q <= 1'b1;
      key_q    <= key_d;
    end
  end

  // Registered player controls and start levels
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      p1_ctrl <= '0;
      p2_ctrl <= '0;
      start1  <= 1'b0;
      start2  <= 1'b0;
    end else begin
      p1_ctrl <= rotate_ctrl(p1_raw, rotate);
      p2_ctrl <= rotate_ctrl(p2_raw, rotate);
      start1  <= start1_d;
      start2  <= start2_d;
    end
  end

  // History for rising-edge coin requests
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      start1_hist <= 1'b0;
      start2_hist <= 1'b0;
      coin_a_hist <= 1'b0;
      coin_b_hist <= 1'b0;
    end else begin
      start1_hist <= start1;
      start2_hist <= start2;
      coin_a_hist <= key_q.coin_a;
      coin_b_hist <= key_q.coin_b;
    end
  end

  assign req_count = {2'b00, start1 & ~start1_hist}
                   + {2'b00, start2 & ~start2_hist}
                   + {2'b00, key_q.coin_a & ~coin_a_hist}
                   + {2'b00, key_q.coin_b & ~coin_b_hist};

  coin_pulse_gen #(
    .COIN_ON_CYCLES (COIN_ON_CYCLES),
    .COIN_OFF_CYCLES(COIN_OFF_CYCLES),
    .QUEUE_MAX      (QUEUE_MAX)
  ) u_coin (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .req_count(req_count),
    .coin     (coin1),
    .pending  (coin_pending)
  );

endmodule
